// File: rtl/laser_cover_cnt_if.sv
// Point-load and coverage-query bus between the search controller and laser_cover_cnt.
// master = controller side, slave = counting engine.
interface laser_cover_cnt_if;
  logic       clr;
  logic       ld_valid;
  logic [3:0] x;
  logic [3:0] y;
  logic       ld_done;
  logic       q_start;
  logic [3:0] q_cx;
  logic [3:0] q_cy;
  logic [3:0] q_ox;
  logic [3:0] q_oy;
  logic       q_oen;
  logic       busy;
  logic       r_valid;
  logic [5:0] r_cnt;

  modport master (
    output clr, ld_valid, x, y, q_start, q_cx, q_cy, q_ox, q_oy, q_oen,
    input  ld_done, busy, r_valid, r_cnt
  );

  modport slave (
    input  clr, ld_valid, x, y, q_start, q_cx, q_cy, q_ox, q_oy, q_oen,
    output ld_done, busy, r_valid, r_cnt
  );
endinterface

// File: rtl/laser_cover_cnt.sv
// Point store plus PAR-wide coverage counter: counts stored points inside the
// candidate circle, or inside the union of candidate and other circle.
//
// state   | meaning
// ST_LOAD | accepting points into entries 0..NPT-1
// ST_IDLE | points stored, waiting for a query
// ST_SCAN | evaluating PAR entries per cycle, NPT/PAR cycles per query
module laser_cover_cnt #(
  parameter int NPT = 40,
  parameter int PAR = 4,
  parameter int R2  = 16
) (
  input logic              clk_i,
  input logic              rst_n_i,
  laser_cover_cnt_if.slave bus_if
);

  localparam int NGRP = NPT / PAR;
  localparam int GW   = $clog2(NGRP + 1);
  localparam int HW   = $clog2(PAR + 1);

  typedef enum logic [1:0] {ST_LOAD, ST_IDLE, ST_SCAN} state_t;

  state_t          state_q, state_d;
  logic [5:0]      ptr_q, ptr_d;
  logic [5:0]      base_q, base_d;
  logic [GW-1:0]   grp_left_q, grp_left_d;
  logic [5:0]      acc_q, acc_d;
  logic [5:0]      r_cnt_q, r_cnt_d;
  logic            r_valid_q, r_valid_d;
  logic            ld_done_q, ld_done_d;
  logic [3:0]      cx_q, cx_d, cy_q, cy_d, ox_q, ox_d, oy_q, oy_d;
  logic            oen_q, oen_d;
  logic            mem_we;
  logic [HW-1:0]   grp_hits;
  logic [3:0]      px_q [NPT];
  logic [3:0]      py_q [NPT];

  // Differences are taken as 5-bit signed so (0,0) vs (15,15) gives -15, not a wrapped value.
  function automatic logic [8:0] dist2(input logic [3:0] ax, input logic [3:0] ay,
                                       input logic [3:0] bx, input logic [3:0] by);
    logic signed [4:0] dx, dy;
    logic [3:0]        mx, my;
    logic [7:0]        sx, sy;
    dx = $signed({1'b0, ax}) - $signed({1'b0, bx});
    dy = $signed({1'b0, ay}) - $signed({1'b0, by});
    mx = dx[4] ? 4'(-dx) : dx[3:0];
    my = dy[4] ? 4'(-dy) : dy[3:0];
    sx = {4'b0, mx} * {4'b0, mx};
    sy = {4'b0, my} * {4'b0, my};
    return {1'b0, sx} + {1'b0, sy};
  endfunction

  function automatic logic is_hit(input logic [3:0] px, input logic [3:0] py);
    logic in_c, in_o;
    in_c = dist2(px, py, cx_q, cy_q) <= 9'(R2);
    in_o = oen_q && (dist2(px, py, ox_q, oy_q) <= 9'(R2));
    return in_c || in_o;
  endfunction

  always_comb begin
    grp_hits = '0;
    for (int p = 0; p < PAR; p++) begin
      if (is_hit(px_q[base_q + 6'(p)], py_q[base_q + 6'(p)]))
        grp_hits = grp_hits + HW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    base_d     = base_q;
    grp_left_d = grp_left_q;
    acc_d      = acc_q;
    r_cnt_d    = r_cnt_q;
    r_valid_d  = 1'b0;
    ld_done_d  = ld_done_q | (state_q != ST_LOAD);
    cx_d       = cx_q;
    cy_d       = cy_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    oen_d      = oen_q;
    mem_we     = 1'b0;

    case (state_q)
      ST_LOAD: begin
        if (bus_if.ld_valid) begin
          mem_we = 1'b1;
          ptr_d  = ptr_q + 6'd1;
          if (ptr_q == 6'(NPT - 1)) state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (bus_if.q_start) begin
          cx_d       = bus_if.q_cx;
          cy_d       = bus_if.q_cy;
          ox_d       = bus_if.q_ox;
          oy_d       = bus_if.q_oy;
          oen_d      = bus_if.q_oen;
          acc_d      = '0;
          base_d     = '0;
          grp_left_d = GW'(NGRP - 1);
          state_d    = ST_SCAN;
        end
      end
      ST_SCAN: begin
        acc_d      = acc_q + 6'(grp_hits);
        base_d     = base_q + 6'(PAR);
        grp_left_d = grp_left_q - GW'(1);
        if (grp_left_q == '0) begin
          state_d   = ST_IDLE;
          r_cnt_d   = acc_q + 6'(grp_hits);
          r_valid_d = 1'b1;
        end
      end
      default: state_d = ST_LOAD;
    endcase

    // Clear overrides any load or query presented in the same cycle.
    if (bus_if.clr) begin
      state_d   = ST_LOAD;
      ptr_d     = '0;
      ld_done_d = 1'b0;
      r_cnt_d   = '0;
      r_valid_d = 1'b0;
      acc_d     = '0;
      mem_we    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_LOAD;
      ptr_q      <= '0;
      base_q     <= '0;
      grp_left_q <= '0;
      acc_q      <= '0;
      r_cnt_q    <= '0;
      r_valid_q  <= 1'b0;
      ld_done_q  <= 1'b0;
      cx_q       <= '0;
      cy_q       <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      oen_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      base_q     <= base_d;
      grp_left_q <= grp_left_d;
      acc_q      <= acc_d;
      r_cnt_q    <= r_cnt_d;
      r_valid_q  <= r_valid_d;
      ld_done_q  <= ld_done_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      oen_q      <= oen_d;
    end
  end

  // Point storage needs no reset; entries are always rewritten before use.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      px_q[ptr_q] <= bus_if.x;
      py_q[ptr_q] <= bus_if.y;
    end
  end

  assign bus_if.ld_done = ld_done_q;
  assign bus_if.busy    = (state_q == ST_SCAN);
  assign bus_if.r_valid = r_valid_q;
  assign bus_if.r_cnt   = r_cnt_q;

endmodule

// File: tb/tb_laser_cover_cnt.sv
// Scoreboard bench for laser_cover_cnt: expected counts queued at query issue,
// compared when R_VALID arrives.
module tb_laser_cover_cnt;

  logic clk;
  logic rst_n;
  laser_cover_cnt_if bus ();

  laser_cover_cnt dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus_if  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_q[$];
  int tx[40];
  int ty[40];

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", tag, act, exp, $time);
    end
  endtask

  function automatic int model_cnt(input int cx, input int cy, input int ox, input int oy,
                                   input bit oen);
    int n;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      int dc, dd;
      dc = (tx[i] - cx) * (tx[i] - cx) + (ty[i] - cy) * (ty[i] - cy);
      dd = (tx[i] - ox) * (tx[i] - ox) + (ty[i] - oy) * (ty[i] - oy);
      if (dc <= 16 || (oen && dd <= 16)) n++;
    end
    return n;
  endfunction

  always @(negedge clk) begin
    if (bus.r_valid && bus.busy) chk("rv_with_busy", 1, 0);
    if (bus.r_valid) begin
      if (exp_q.size() == 0) chk("spurious_r_valid", 1, 0);
      else chk("r_cnt", int'(bus.r_cnt), exp_q.pop_front());
    end
  end

  task automatic set_all(input int x, input int y);
    for (int i = 0; i < 40; i++) begin
      tx[i] = x;
      ty[i] = y;
    end
  endtask

  task automatic load_points(input bit poke);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (poke && i == 21) chk("busy_during_load", int'(bus.busy), 0);
      bus.ld_valid = 1'b1;
      bus.x        = 4'(tx[i]);
      bus.y        = 4'(ty[i]);
      bus.q_start  = poke && (i == 20);
    end
    @(negedge clk);
    bus.ld_valid = 1'b0;
    bus.q_start  = 1'b0;
    chk("ld_done_lag", int'(bus.ld_done), 0);
    @(negedge clk);
    chk("ld_done", int'(bus.ld_done), 1);
  endtask

  // Waits for R_VALID; returns cycles since the start strobe cycle and BUSY cycles seen.
  task automatic wait_rv(output int lat, output int nbusy);
    lat   = 1;
    nbusy = bus.busy ? 1 : 0;
    while (!bus.r_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus.busy) nbusy++;
    end
    if (!bus.r_valid) chk("timeout_r_valid", 0, 1);
  endtask

  task automatic do_query(input string tag, input int cx, input int cy, input int ox,
                          input int oy, input bit oen, input int exp, input bit same_cycle);
    int lat, nbusy;
    if (!same_cycle) @(negedge clk);
    bus.q_cx    = 4'(cx);
    bus.q_cy    = 4'(cy);
    bus.q_ox    = 4'(ox);
    bus.q_oy    = 4'(oy);
    bus.q_oen   = oen;
    bus.q_start = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    bus.q_start = 1'b0;
    bus.q_cx    = 4'($urandom_range(0, 15));
    bus.q_cy    = 4'($urandom_range(0, 15));
    bus.q_ox    = 4'($urandom_range(0, 15));
    bus.q_oy    = 4'($urandom_range(0, 15));
    bus.q_oen   = 1'($urandom_range(0, 1));
    wait_rv(lat, nbusy);
    chk({tag, "_latency"}, lat, 11);
    chk({tag, "_busy_cycles"}, nbusy, 10);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nbusy;
    rst_n        = 1'b0;
    bus.clr      = 1'b0;
    bus.ld_valid = 1'b0;
    bus.x        = '0;
    bus.y        = '0;
    bus.q_start  = 1'b0;
    bus.q_cx     = '0;
    bus.q_cy     = '0;
    bus.q_ox     = '0;
    bus.q_oy     = '0;
    bus.q_oen    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ld_done", int'(bus.ld_done), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_r_valid", int'(bus.r_valid), 0);
    chk("rst_r_cnt", int'(bus.r_cnt), 0);
    rst_n = 1'b1;

    // All points on the centre; query issued in the first LD_DONE cycle.
    set_all(8, 8);
    load_points(1'b0);
    do_query("all_centre", 8, 8, 0, 0, 1'b0, 40, 1'b1);

    // Radius boundary and union.
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    set_all(0, 15);
    tx[0] = 4;  ty[0] = 8;
    tx[1] = 12; ty[1] = 8;
    tx[2] = 8;  ty[2] = 4;
    tx[3] = 8;  ty[3] = 12;
    tx[4] = 5;  ty[4] = 5;
    load_points(1'b0);
    do_query("radius_edge", 8, 8, 0, 15, 1'b0, 4, 1'b0);
    do_query("union", 8, 8, 0, 15, 1'b1, 39, 1'b0);
    do_query("union_same", 8, 8, 8, 8, 1'b1, 4, 1'b0);
    do_query("union_off", 8, 8, 0, 15, 1'b0, 4, 1'b0);

    // Sign / no-wrap, with a query poked during load.
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    set_all(0, 0);
    load_points(1'b1);
    do_query("far_corner", 15, 15, 0, 0, 1'b0, 0, 1'b0);
    do_query("diag_2_2", 2, 2, 0, 0, 1'b0, 40, 1'b0);
    do_query("axis_0_4", 0, 4, 0, 0, 1'b0, 40, 1'b0);
    do_query("axis_0_5", 0, 5, 0, 0, 1'b0, 0, 1'b0);

    // Back-to-back: second start in the R_VALID cycle.
    do_query("b2b_first", 2, 2, 0, 0, 1'b0, 40, 1'b0);
    do_query("b2b_second", 0, 5, 0, 0, 1'b0, 0, 1'b1);

    // Start while busy is ignored.
    @(negedge clk);
    bus.q_cx = 4'd0; bus.q_cy = 4'd4; bus.q_oen = 1'b0; bus.q_start = 1'b1;
    exp_q.push_back(40);
    @(negedge clk);
    bus.q_start = 1'b0;
    @(negedge clk);
    chk("busy_mid_scan", int'(bus.busy), 1);
    bus.q_cx = 4'd15; bus.q_cy = 4'd15; bus.q_start = 1'b1;
    @(negedge clk);
    bus.q_start = 1'b0;
    wait_rv(lat, nbusy);
    chk("busy_ignore_latency", lat, 9);
    repeat (15) @(negedge clk);
    chk("no_second_busy", int'(bus.busy), 0);

    // Extra loads in IDLE must not disturb the stored points.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.ld_valid = 1'b1;
      bus.x = 4'd15;
      bus.y = 4'd15;
    end
    @(negedge clk);
    bus.ld_valid = 1'b0;
    do_query("after_extra_ld", 0, 4, 0, 0, 1'b0, 40, 1'b0);

    // Clear in the fifth scan cycle.
    @(negedge clk);
    bus.q_cx = 4'd0; bus.q_cy = 4'd0; bus.q_oen = 1'b0; bus.q_start = 1'b1;
    exp_q.push_back(40);
    @(negedge clk);
    bus.q_start = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_before_clr", int'(bus.busy), 1);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    exp_q.delete();
    chk("clr_ld_done", int'(bus.ld_done), 0);
    chk("clr_r_cnt", int'(bus.r_cnt), 0);
    chk("clr_busy", int'(bus.busy), 0);
    repeat (15) @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      tx[i] = $urandom_range(0, 15);
      ty[i] = $urandom_range(0, 15);
    end
    load_points(1'b0);
    for (int k = 0; k < 4; k++) begin
      int cx, cy, ox, oy;
      bit oen;
      cx  = $urandom_range(0, 15);
      cy  = $urandom_range(0, 15);
      ox  = $urandom_range(0, 15);
      oy  = $urandom_range(0, 15);
      oen = 1'($urandom_range(0, 1));
      do_query("reload_rand", cx, cy, ox, oy, oen, model_cnt(cx, cy, ox, oy, oen), 1'b0);
    end

    // Asynchronous reset mid-scan: outputs drop without a clock edge.
    do_query("pre_rst", tx[0], ty[0], 0, 0, 1'b0, model_cnt(tx[0], ty[0], 0, 0, 1'b0), 1'b0);
    @(negedge clk);
    bus.q_cx = 4'(tx[1]); bus.q_cy = 4'(ty[1]); bus.q_oen = 1'b0; bus.q_start = 1'b1;
    exp_q.push_back(model_cnt(tx[1], ty[1], 0, 0, 1'b0));
    @(negedge clk);
    bus.q_start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_ld_done", int'(bus.ld_done), 0);
    chk("arst_r_valid", int'(bus.r_valid), 0);
    chk("arst_r_cnt", int'(bus.r_cnt), 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tx[i] = $urandom_range(4, 11);
      ty[i] = $urandom_range(4, 11);
    end
    load_points(1'b0);
    for (int k = 0; k < 3; k++) begin
      int cx, cy, ox, oy;
      cx = $urandom_range(2, 13);
      cy = $urandom_range(2, 13);
      ox = $urandom_range(2, 13);
      oy = $urandom_range(2, 13);
      do_query("post_rst_rand", cx, cy, ox, oy, 1'b1, model_cnt(cx, cy, ox, oy, 1'b1), 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
